// File: rtl/tick_scheduler.sv
// tick_scheduler: shared timebase for the IO devices.
// A free-running prescaler emits a one-cycle base_tick every PRESCALE clocks.
// Each of NCH channels counts base ticks and raises a pending event every
// `period` ticks; the event is held until the owner acknowledges it, and a
// sticky overrun flag records events that fired on top of an unacked one.
// Optional feature macro: TICK_SCHEDULER_ONESHOT_EN adds a per-channel
// one-shot mode (cfg_oneshot port) that disables the channel after it fires.
module tick_scheduler #(
    parameter int PRESCALE = 12500000,
    parameter int NCH      = 4,
    parameter int CHW      = 2,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic            cfg_en,
    input  logic [CNTW-1:0] cfg_period,
`ifdef TICK_SCHEDULER_ONESHOT_EN
    input  logic            cfg_oneshot,
`endif
    input  logic [NCH-1:0]  ch_ack,
    output logic            base_tick,
    output logic [NCH-1:0]  ch_pend,
    output logic [NCH-1:0]  ch_ovr
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0]   pcnt;
    logic [NCH-1:0]  en;
    logic [CNTW-1:0] period [NCH];
    logic [CNTW-1:0] cnt    [NCH];
`ifdef TICK_SCHEDULER_ONESHOT_EN
    logic [NCH-1:0]  oneshot;
`endif

    logic [NCH-1:0]  wr;
    logic [NCH-1:0]  tick_on;
    logic [NCH-1:0]  fire;

    // Free-running prescaler; base_tick is the registered wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt      <= '0;
            base_tick <= 1'b0;
        end else if (pcnt == PLAST) begin
            pcnt      <= '0;
            base_tick <= 1'b1;
        end else begin
            pcnt      <= pcnt + PW'(1);
            base_tick <= 1'b0;
        end
    end

    // Per-channel decode: a config write to a channel masks its tick that cycle.
    always_comb begin
        wr      = '0;
        tick_on = '0;
        fire    = '0;
        for (int i = 0; i < NCH; i++) begin
            wr[i]      = cfg_we && (cfg_ch == CHW'(i));
            tick_on[i] = !wr[i] && base_tick && en[i] && (period[i] != '0);
            fire[i]    = tick_on[i] && (cnt[i] == CNTW'(1));
        end
    end

    // Channel configuration, countdown/reload, and pending/overrun tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= '0;
            ch_pend <= '0;
            ch_ovr  <= '0;
`ifdef TICK_SCHEDULER_ONESHOT_EN
            oneshot <= '0;
`endif
            for (int i = 0; i < NCH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr[i]) begin
                    en[i]     <= cfg_en;
                    period[i] <= cfg_period;
                    cnt[i]    <= cfg_period;
`ifdef TICK_SCHEDULER_ONESHOT_EN
                    oneshot[i] <= cfg_oneshot;
`endif
                end else if (fire[i]) begin
                    cnt[i] <= period[i];
`ifdef TICK_SCHEDULER_ONESHOT_EN
                    if (oneshot[i]) begin
                        en[i] <= 1'b0;
                    end
`endif
                end else if (tick_on[i]) begin
                    cnt[i] <= cnt[i] - CNTW'(1);
                end

                if (fire[i]) begin
                    ch_pend[i] <= 1'b1;
                    if (ch_ack[i]) begin
                        ch_ovr[i] <= 1'b0;
                    end else if (ch_pend[i]) begin
                        ch_ovr[i] <= 1'b1;
                    end
                end else if (ch_ack[i]) begin
                    ch_pend[i] <= 1'b0;
                    ch_ovr[i]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: directed bench for tick_scheduler with PRESCALE=4,
// NCH=4, CNTW=4, plus a second NCH=3 instance for the out-of-range write.
// Cycle N is the clock period whose closing edge is the Nth edge after rst
// falls; inputs set in cycle N are sampled by edge N, outputs read in cycle N
// are the values that edge N sees.
module tb_tick_scheduler;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic       cfg_we3;
    logic [1:0] cfg_ch;
    logic       cfg_en;
    logic [3:0] cfg_period;
`ifdef TICK_SCHEDULER_ONESHOT_EN
    logic       cfg_oneshot;
`endif
    logic [3:0] ch_ack;
    logic [2:0] ack3;
    logic       base_tick;
    logic [3:0] ch_pend;
    logic [3:0] ch_ovr;
    logic       base_tick3;
    logic [2:0] ch_pend3;
    logic [2:0] ch_ovr3;

    int cyc;
    int vectors;
    int miscompares;

    tick_scheduler #(.PRESCALE(4), .NCH(4), .CHW(2), .CNTW(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_en     (cfg_en),
        .cfg_period (cfg_period),
`ifdef TICK_SCHEDULER_ONESHOT_EN
        .cfg_oneshot(cfg_oneshot),
`endif
        .ch_ack     (ch_ack),
        .base_tick  (base_tick),
        .ch_pend    (ch_pend),
        .ch_ovr     (ch_ovr)
    );

    tick_scheduler #(.PRESCALE(4), .NCH(3), .CHW(2), .CNTW(4)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we3),
        .cfg_ch     (cfg_ch),
        .cfg_en     (cfg_en),
        .cfg_period (cfg_period),
`ifdef TICK_SCHEDULER_ONESHOT_EN
        .cfg_oneshot(cfg_oneshot),
`endif
        .ch_ack     (ack3),
        .base_tick  (base_tick3),
        .ch_pend    (ch_pend3),
        .ch_ovr     (ch_ovr3)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; one-cycle strobes drop after their edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        cfg_we  = 1'b0;
        cfg_we3 = 1'b0;
        ch_ack  = 4'b0000;
    endtask

    // Advance until the current cycle number reaches c.
    task automatic tick_to(input int c);
        while (cyc < c) step();
    endtask

    // Drive a config write for the current cycle.
    task automatic apply_stimulus(input logic [1:0] ch, input logic en, input logic [3:0] per);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_en     = en;
        cfg_period = per;
    endtask

    // Directed sequence.
    initial begin
        clk = 1'b0; rst = 1'b1; cfg_we = 1'b0; cfg_we3 = 1'b0; cfg_ch = 2'd0;
        cfg_en = 1'b0; cfg_period = 4'd0; ch_ack = 4'b0000; ack3 = 3'b000;
`ifdef TICK_SCHEDULER_ONESHOT_EN
        cfg_oneshot = 1'b0;
`endif
        vectors = 0; miscompares = 0; cyc = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("rst_base_tick", {7'd0, base_tick}, 8'h00);
        check_output("rst_pend", {4'd0, ch_pend}, 8'h00);
        check_output("rst_ovr", {4'd0, ch_ovr}, 8'h00);

        // Prescaler and periodic/overrun channels.
        rst = 1'b0; cyc = 1;
        apply_stimulus(2'd0, 1'b1, 4'd2);
        check_output("c1_base_tick", {7'd0, base_tick}, 8'h00);
        step();
        apply_stimulus(2'd1, 1'b1, 4'd1);
        tick_to(4);  check_output("c4_base_tick", {7'd0, base_tick}, 8'h00);
        tick_to(5);  check_output("c5_base_tick", {7'd0, base_tick}, 8'h01);
                     check_output("c5_pend", {4'd0, ch_pend}, 8'h00);
        tick_to(6);  check_output("c6_base_tick", {7'd0, base_tick}, 8'h00);
                     check_output("c6_pend", {4'd0, ch_pend}, 8'h02);
                     check_output("c6_ovr", {4'd0, ch_ovr}, 8'h00);
        tick_to(9);  check_output("c9_base_tick", {7'd0, base_tick}, 8'h01);
        tick_to(10); check_output("c10_pend", {4'd0, ch_pend}, 8'h03);
                     check_output("c10_ovr", {4'd0, ch_ovr}, 8'h02);
        tick_to(11); ch_ack = 4'b0001;
        tick_to(12); check_output("c12_pend", {4'd0, ch_pend}, 8'h02);
                     check_output("c12_ovr", {4'd0, ch_ovr}, 8'h02);
                     ch_ack = 4'b0010;
        tick_to(13); check_output("c13_pend", {4'd0, ch_pend}, 8'h00);
                     check_output("c13_ovr", {4'd0, ch_ovr}, 8'h00);
                     check_output("c13_base_tick", {7'd0, base_tick}, 8'h01);
        tick_to(14); check_output("c14_pend", {4'd0, ch_pend}, 8'h02);

        // Ack on the tick cycle, and a write on the tick cycle.
        tick_to(17); ch_ack = 4'b0010;
        tick_to(18); check_output("c18_pend", {4'd0, ch_pend}, 8'h03);
                     check_output("c18_ovr", {4'd0, ch_ovr}, 8'h00);
        tick_to(19); ch_ack = 4'b0001;
        tick_to(20); check_output("c20_pend", {4'd0, ch_pend}, 8'h02);
        tick_to(21); check_output("c21_base_tick", {7'd0, base_tick}, 8'h01);
                     apply_stimulus(2'd2, 1'b1, 4'd3);
        tick_to(22); check_output("c22_pend", {4'd0, ch_pend}, 8'h02);
                     check_output("c22_ovr", {4'd0, ch_ovr}, 8'h02);
        tick_to(26); check_output("c26_pend", {4'd0, ch_pend}, 8'h03);
        tick_to(27); ch_ack = 4'b0001;
        tick_to(30); check_output("c30_pend_no_early_ch2", {4'd0, ch_pend}, 8'h02);
        tick_to(34); check_output("c34_pend", {4'd0, ch_pend}, 8'h07);
                     check_output("c34_ovr", {4'd0, ch_ovr}, 8'h02);

        // Disable ch0 while pending.
                     apply_stimulus(2'd0, 1'b0, 4'd2);
        tick_to(35); ch_ack = 4'b0110;
        tick_to(36); check_output("c36_pend", {4'd0, ch_pend}, 8'h01);
                     check_output("c36_ovr", {4'd0, ch_ovr}, 8'h00);
        tick_to(38); check_output("c38_pend", {4'd0, ch_pend}, 8'h03);
        tick_to(42); check_output("c42_pend", {4'd0, ch_pend}, 8'h03);
                     check_output("c42_ovr_ch0_idle", {4'd0, ch_ovr}, 8'h02);
                     ch_ack = 4'b0001;
        tick_to(43); check_output("c43_pend", {4'd0, ch_pend}, 8'h02);

        // period=0 never fires; out-of-range channel write on NCH=3 instance.
                     apply_stimulus(2'd3, 1'b1, 4'd0);
        tick_to(44); cfg_we3 = 1'b1; cfg_ch = 2'd3; cfg_en = 1'b1; cfg_period = 4'd1;
        tick_to(46); check_output("c46_pend", {4'd0, ch_pend}, 8'h06);
        tick_to(50); check_output("c50_pend_period0", {4'd0, ch_pend}, 8'h06);
                     check_output("c50_ovr", {4'd0, ch_ovr}, 8'h02);
                     check_output("c50_nch3_pend", {5'd0, ch_pend3}, 8'h00);
                     check_output("c50_nch3_ovr", {5'd0, ch_ovr3}, 8'h00);

        // Reset mid-count, colliding with a config write.
                     rst = 1'b1;
                     apply_stimulus(2'd0, 1'b1, 4'd1);
        step();
        check_output("rst2_pend", {4'd0, ch_pend}, 8'h00);
        check_output("rst2_ovr", {4'd0, ch_ovr}, 8'h00);
        check_output("rst2_base_tick", {7'd0, base_tick}, 8'h00);
        rst = 1'b0; cyc = 1;
`ifdef TICK_SCHEDULER_ONESHOT_EN
        apply_stimulus(2'd3, 1'b1, 4'd2);
        cfg_oneshot = 1'b1;
`endif
        tick_to(4);  check_output("r4_base_tick", {7'd0, base_tick}, 8'h00);
        tick_to(5);  check_output("r5_base_tick", {7'd0, base_tick}, 8'h01);
        tick_to(6);  check_output("r6_pend", {4'd0, ch_pend}, 8'h00);

`ifdef TICK_SCHEDULER_ONESHOT_EN
        // One-shot channel fires once, then again only after a rewrite.
        tick_to(9);  check_output("os9_pend", {4'd0, ch_pend}, 8'h00);
        tick_to(10); check_output("os10_pend", {4'd0, ch_pend}, 8'h08);
        tick_to(11); ch_ack = 4'b1000;
        tick_to(12); check_output("os12_pend", {4'd0, ch_pend}, 8'h00);
        tick_to(26); check_output("os26_pend", {4'd0, ch_pend}, 8'h00);
                     check_output("os26_ovr", {4'd0, ch_ovr}, 8'h00);
                     apply_stimulus(2'd3, 1'b1, 4'd2);
                     cfg_oneshot = 1'b1;
        tick_to(33); check_output("os33_pend", {4'd0, ch_pend}, 8'h00);
        tick_to(34); check_output("os34_pend", {4'd0, ch_pend}, 8'h08);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Shared timebase scheduler for the IO devices (serial, display scan, LED blink).
- One free-running prescaler produces a base tick, 0.25 s at 50 MHz by default.
- NCH independently programmable channels each count base ticks and raise a pending event every P ticks.
- Each event is held until the owning requester acknowledges it, replacing per-device private dividers.

Parameters:
- PRESCALE, 12500000, clk cycles per base tick (>=2).
- NCH, 4, number of channels (1..16).
- CHW, 2, channel index width; must satisfy 2^CHW >= NCH.
- CNTW, 16, period/countdown width in base ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_ch  in  CHW  channel addressed by the write; writes with cfg_ch >= NCH are ignored.
- cfg_en  in  1  channel enable value to write.
- cfg_period  in  CNTW  period in base ticks; 0 means the channel never fires.
- cfg_oneshot  in  1  one-shot mode bit; present only with the optional feature.
- ch_ack  in  NCH  per-channel acknowledge; clears pending.
- base_tick  out  1  one-cycle pulse per prescaler wrap.
- ch_pend  out  NCH  per-channel pending event, level.
- ch_ovr  out  NCH  per-channel sticky overrun flag.

Behaviour:
- Reset: pcnt=0, base_tick=0, all en/period/cnt=0, ch_pend=0, ch_ovr=0. rst has priority over every other input in the same cycle.
- Prescaler:
  - pcnt increments every cycle.
  - At pcnt==PRESCALE-1: pcnt<=0 and base_tick<=1 for exactly the next cycle; otherwise base_tick<=0.
  - First base_tick is high in cycle PRESCALE+1 after rst falls, cycle 1 being the first edge with rst=0.
  - Period is exactly PRESCALE cycles. The prescaler never stops.
- Channel config write (cfg_we, valid cfg_ch):
  - en<=cfg_en, period<=cfg_period, cnt<=cfg_period.
  - ch_pend and ch_ovr are unchanged.
  - If a write coincides with base_tick, the write wins for that channel: no decrement and no fire that cycle.
- Channel tick processing, on a cycle with base_tick=1 and en=1 and period!=0:
  - cnt>1: cnt<=cnt-1.
  - cnt==1: fire; cnt<=period.
  - Channels with en=0 or period=0 hold cnt.
- Fire:
  - ch_pend[i]<=1, visible the cycle after base_tick.
  - If ch_pend[i] was already 1 and ch_ack[i]=0 that cycle, ch_ovr[i]<=1.
  - The first event for period P configured before the first tick appears P base ticks after configuration.
- Ack:
  - ch_ack[i]=1 clears ch_pend[i] and ch_ovr[i] next cycle.
  - Ack and fire in the same cycle: ch_pend[i] stays 1 (new event), ch_ovr[i]<=0.
  - Ack while not pending has no effect.
- Disable (cfg_en=0): the channel stops counting. A pending event remains until acked.
- Wrap-around: cnt never underflows; reload occurs on the cycle it would reach 0.
- Ignored bits: ch_ack bits for channels beyond NCH do not exist. cfg writes to cfg_ch >= NCH have no side effects.

Optional Feature:
- Macro: TICK_SCHEDULER_ONESHOT_EN.
- Defined:
  - Adds the cfg_oneshot port and a per-channel mode bit, written with the config.
  - A one-shot channel fires once, then clears its en bit itself (cnt<=period) and stays idle until rewritten.
- Undefined:
  - No cfg_oneshot port and no mode bit; every channel is periodic.

Test Plan:
Bench uses PRESCALE=4, NCH=4, CNTW=4.
1. Prescaler: release rst, idle -> base_tick high in cycles 5, 9, 13; single-cycle pulses; ch_pend=0000.
2. Periodic channel: cycle 1 write ch0 en=1 period=2; ack each event 1 cycle after it rises -> ch_pend[0] rises in cycles 10, 18, 26; ch_ovr[0] stays 0.
3. Overrun: ch1 period=1, never ack -> ch_pend[1]=1 from cycle 6, ch_ovr[1]=1 from cycle 10. Then ack ch1 in a non-tick cycle -> both 0 next cycle.
4. Simultaneous events:
   - Ack ch1 in the exact base_tick cycle -> ch_pend[1] stays 1, ch_ovr[1]=0.
   - Write ch2 period=3 in a base_tick cycle -> no decrement that tick; first fire 3 ticks later.
5. Edge config:
   - period=0 with en=1 -> never pends.
   - cfg_ch=3 with NCH=3 -> no change to any channel.
   - Disable ch0 while pending -> pend held until ack, no further fires.
   - Assert rst mid-count -> all outputs 0 next cycle; prescaler restarts from 0.
6. With TICK_SCHEDULER_ONESHOT_EN: ch3 period=2 oneshot=1 -> single ch_pend[3] rise at cycle 10, none afterwards. Rewrite ch3 -> fires once more 2 ticks later.
